// File: rtl/hamming_encode_engine_pkg.sv
// Shared SECDED (16,11) types, FSM encoding and the reference encode function.
// The decoder stage and the benches import the same function.
package hamming_pkg;
  typedef logic [11:1] msg_t;
  typedef logic [15:0] cw_t;

  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int P4 = 4;
  localparam int P8 = 8;

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

  // Data bits occupy the non-power-of-two positions; p0 gives even parity over all 16 bits.
  function automatic cw_t hamming_encode(msg_t d);
    cw_t cw;
    cw        = '0;
    cw[15:9]  = d[11:5];
    cw[7:5]   = d[4:2];
    cw[3]     = d[1];
    cw[P8]    = ^d[11:5];
    cw[P4]    = (^d[11:8]) ^ (^d[4:2]);
    cw[P2]    = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    cw[P1]    = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    cw[P0]    = ^cw[15:1];
    return cw;
  endfunction
endpackage

// File: rtl/hamming_encode_engine_if.sv
// Start/done handshake plus the shared byte-wide data-memory port.
interface hamming_encode_engine_if #(parameter int AW = 8);
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd_data;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_data;

  modport master (input start, mem_rd_data,
                  output busy, done, mem_addr, mem_wr_en, mem_wr_data);
  modport slave  (output start, mem_rd_data,
                  input busy, done, mem_addr, mem_wr_en, mem_wr_data);
endinterface

// File: rtl/hamming_encode_engine_enc11.sv
// Pure combinational 11-bit message to 16-bit SECDED codeword.
module hamming_enc11
  import hamming_pkg::*;
(
  input  msg_t msg,
  output cw_t  cw
);
  assign cw = hamming_encode(msg);
endmodule

// File: rtl/hamming_encode_engine.sv
// Walks NUM_MSG byte-pair messages from SRC_BASE and writes SECDED codewords to DST_BASE.
// Four memory cycles per message; the codeword is formed combinationally from the latched bytes.
module hamming_encode_engine
  import hamming_pkg::*;
#(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int AW       = 8
) (
  input logic clk,
  input logic reset,
  hamming_encode_engine_if.master bus
);
  localparam logic [6:0] LAST = 7'(NUM_MSG - 1);

  state_t        state;
  logic [6:0]    idx;
  logic [7:0]    lo_q;
  logic [2:0]    hi_q;
  logic          busy_q, done_q;
  cw_t           cw;
  logic [AW-1:0] src_a, dst_a;

  hamming_enc11 u_enc (.msg({hi_q, lo_q}), .cw(cw));

  // Byte offset 2*idx wraps modulo 2^AW together with the base.
  assign src_a = AW'(SRC_BASE) + AW'({idx, 1'b0});
  assign dst_a = AW'(DST_BASE) + AW'({idx, 1'b0});

  assign bus.busy = busy_q;
  assign bus.done = done_q;

  always_comb begin
    bus.mem_addr    = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_data = '0;
    case (state)
      RD_LO: bus.mem_addr = src_a;
      RD_HI: bus.mem_addr = src_a + AW'(1);
      WR_LO: begin
        bus.mem_addr    = dst_a;
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = cw[7:0];
      end
      WR_HI: begin
        bus.mem_addr    = dst_a + AW'(1);
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = cw[15:8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      idx    <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state  <= RD_LO;
          idx    <= '0;
          done_q <= 1'b0;
          busy_q <= 1'b1;
        end
        RD_LO: begin
          lo_q   <= bus.mem_rd_data;
          done_q <= 1'b0;
          state  <= RD_HI;
        end
        RD_HI: begin
          hi_q  <= bus.mem_rd_data[2:0];
          state <= WR_LO;
        end
        WR_LO: state <= WR_HI;
        WR_HI: if (idx == LAST) begin
          state  <= DONE;
          busy_q <= 1'b0;
        end else begin
          idx   <= idx + 7'd1;
          state <= RD_LO;
        end
        // done rises on the first DONE cycle even if start is already high, so a
        // held start still yields a one-cycle done pulse before the next run.
        DONE: begin
          done_q <= 1'b1;
          if (bus.start) begin
            state  <= RD_LO;
            idx    <= '0;
            busy_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
